// File: rtl/frame_capture_pkg.sv
// Shared types and widths for the frame capture controller and its output FIFO.
// Geometry counters are sized for frames up to 4096x4096.
package frame_capture_pkg;

    localparam int CNT_W    = 16;
    localparam int PIX_W    = 24;
    localparam int GEOM_MAX = 4096;
    localparam int X_W      = $clog2(GEOM_MAX);
    localparam int Y_W      = $clog2(GEOM_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DROP,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [PIX_W-1:0] tdata;
        logic             tuser;
        logic             tlast;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/stream_fifo.sv
// First-word-fall-through synchronous FIFO holding AXI4-Stream beats.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module stream_fifo
    import frame_capture_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_en,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_wr, do_rd;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign rd_data = mem_q[rp_q];

    always_comb begin
        do_rd = rd_en && !empty;
        do_wr = wr_en && (!full || do_rd);
        wp_d  = do_wr ? wp_q + 1'b1 : wp_q;
        rp_d  = do_rd ? rp_q + 1'b1 : rp_q;
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: empty gates everything read from it.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q] <= wr_data;
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Camera-to-AXI4-Stream frame capture: SOF alignment, tuser/tlast regeneration, drop on corruption.
// Define FRAME_CAPTURE_TEST_PATTERN_EN to add cfg_pattern (x/y/frame-count test pattern data).
module frame_capture_ctrl
    import frame_capture_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 24
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              cfg_enable,
    input  logic              cfg_single,
`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
    input  logic              cfg_pattern,
`endif
    input  logic [7:0]        i_r,
    input  logic [7:0]        i_g,
    input  logic [7:0]        i_b,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic              i_eol,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic              sts_busy,
    output logic              sts_frame_done,
    output logic              sts_overflow,
    output logic              sts_err_len,
    output logic [CNT_W-1:0]  sts_frame_cnt
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             shot_q, shot_d;

    logic             wr_en, rd_en, full, empty;
    fifo_entry_t      wr_entry, rd_entry;
    logic [ENTRY_W-1:0] rd_raw;
    logic             px_take, px_start, px_last_x;
    logic [X_W-1:0]   px_x;
    logic [Y_W-1:0]   px_y;

    assign rd_en    = m_tready && !empty;
    assign rd_entry = rd_raw;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        err_d    = err_q;
        // A finished single shot stays parked in IDLE until cfg_enable is dropped.
        shot_d   = shot_q && cfg_enable;
        px_take  = 1'b0;
        px_start = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            ST_IDLE:
                if (cfg_enable && !shot_q) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF, ST_DROP:
                if (!cfg_enable)           state_d = ST_DRAIN;
                else if (i_valid && i_sof) begin
                    px_take  = 1'b1;
                    px_start = 1'b1;
                end
            ST_CAPTURE:
                if (i_valid) begin
                    px_take  = 1'b1;
                    px_start = i_sof;
                    if (i_sof) err_d = 1'b1;
                end
            ST_DRAIN:
                if (empty) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase

        px_x      = px_start ? '0 : x_q;
        px_y      = px_start ? '0 : y_q;
        px_last_x = (px_x == X_LAST);

`ifdef FRAME_CAPTURE_TEST_PATTERN_EN
        wr_entry.tdata = cfg_pattern ? {px_x[7:0], px_y[7:0], cnt_q[7:0]} : {i_r, i_g, i_b};
`else
        wr_entry.tdata = {i_r, i_g, i_b};
`endif
        wr_entry.tuser = px_start;
        wr_entry.tlast = px_last_x;

        if (px_take) begin
            if (i_eol != px_last_x) err_d = 1'b1;
            if (full && !rd_en) begin
                ovf_d   = 1'b1;
                state_d = ST_DROP;
            end else begin
                wr_en = 1'b1;
                if (!px_last_x) begin
                    x_d     = px_x + 1'b1;
                    y_d     = px_y;
                    state_d = ST_CAPTURE;
                end else if (px_y != Y_LAST) begin
                    x_d     = '0;
                    y_d     = px_y + 1'b1;
                    state_d = ST_CAPTURE;
                end else begin
                    x_d     = '0;
                    y_d     = '0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cfg_single) shot_d = 1'b1;
                    state_d = (cfg_single || !cfg_enable) ? ST_DRAIN : ST_WAIT_SOF;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            shot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            shot_q  <= shot_d;
        end
    end

    stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_en   (wr_en),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_data (rd_raw),
        .full    (full),
        .empty   (empty)
    );

    assign m_tvalid       = !empty;
    assign m_tdata        = empty ? '0 : rd_entry.tdata;
    assign m_tuser        = !empty && rd_entry.tuser;
    assign m_tlast        = !empty && rd_entry.tlast;
    assign sts_busy       = (state_q != ST_IDLE);
    assign sts_frame_done = done_q;
    assign sts_overflow   = ovf_q;
    assign sts_err_len    = err_q;
    assign sts_frame_cnt  = cnt_q;

endmodule
